// File: rtl/cpu_types_pkg.sv
// Shared CPU types: opcodes, ALU ops, register selects and the ID/EX latch record.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [5:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    JAL   = 6'h03,
    BEQ   = 6'h04,
    BNE   = 6'h05,
    ADDI  = 6'h08,
    ADDIU = 6'h09,
    SLTI  = 6'h0a,
    SLTIU = 6'h0b,
    ANDI  = 6'h0c,
    ORI   = 6'h0d,
    XORI  = 6'h0e,
    LUI   = 6'h0f,
    LW    = 6'h23,
    SW    = 6'h2b,
    HALT  = 6'h3f
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR,  ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef struct packed {
    word_t    rdat1;
    word_t    rdat2;
    word_t    imm;
    word_t    laddr;
    word_t    pc_addr;
    regbits_t read1;
    regbits_t read2;
    regbits_t wsel;
    aluop_t   op;
    opcode_t  opcode;
    logic     beq;
    logic     bne;
    logic     jsig;
    logic     jrsig;
    logic     dren;
    logic     dwen;
    logic     reg_wr;
    logic     write_sig;
    logic     imm_sig;
    logic     halt;
  } id_ex_t;

  // RTYPE encodes as zero, so the all-zero record is already a bubble with opcode RTYPE.
  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/decode_execute_latch_load_use_detect.sv
// Load-use hazard compare: a load sitting in EX whose destination is read by the
// instruction currently in decode. $zero destinations never conflict.
import cpu_types_pkg::*;

module load_use_detect (
  input  logic     dren_i,
  input  logic     reg_wr_i,
  input  regbits_t wsel_i,
  input  regbits_t read1_i,
  input  regbits_t read2_i,
  output logic     lu_stall_o
);

  // Purely combinational so fetch/decode see the stall in the same cycle.
  assign lu_stall_o = dren_i & reg_wr_i & (wsel_i != '0) &
                      ((wsel_i == read1_i) | (wsel_i == read2_i));

endmodule

// File: rtl/decode_execute_latch.sv
// ID/EX pipeline register with flush, load-use bubble insertion and a saturating
// bubble counter for performance monitoring.
import cpu_types_pkg::*;

module decode_execute_latch #(
  parameter int DW    = WORD_W,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             decode_en,
  input  logic [DW-1:0]    rdat1i,
  input  logic [DW-1:0]    rdat2i,
  input  logic [DW-1:0]    immi,
  input  logic [DW-1:0]    laddri,
  input  logic [DW-1:0]    pcAddrOuti,
  input  logic [4:0]       read1i,
  input  logic [4:0]       read2i,
  input  logic [4:0]       wseli,
  input  logic [3:0]       opi,
  input  logic [5:0]       decode_opcodei,
  input  logic             beqi,
  input  logic             bnei,
  input  logic             jsigi,
  input  logic             jrsigi,
  input  logic             dRENi,
  input  logic             dWENi,
  input  logic             reg_wri,
  input  logic             write_sigi,
  input  logic             immSigi,
  input  logic             halti,
  output logic [DW-1:0]    rdat1o,
  output logic [DW-1:0]    rdat2o,
  output logic [DW-1:0]    immo,
  output logic [DW-1:0]    laddro,
  output logic [DW-1:0]    pcAddrOuto,
  output logic [4:0]       read1o,
  output logic [4:0]       read2o,
  output logic [4:0]       wselo,
  output logic [3:0]       opo,
  output logic [5:0]       decode_opcodeo,
  output logic             beqo,
  output logic             bneo,
  output logic             jsigo,
  output logic             jrsigo,
  output logic             dRENo,
  output logic             dWENo,
  output logic             reg_wro,
  output logic             write_sigo,
  output logic             immSigo,
  output logic             halto,
  output logic             lu_stall,
  output logic [CNT_W-1:0] bubble_cnt
);

  id_ex_t           ex_q, ex_d, cap;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  load_use_detect u_lud (
    .dren_i     (ex_q.dren),
    .reg_wr_i   (ex_q.reg_wr),
    .wsel_i     (ex_q.wsel),
    .read1_i    (read1i),
    .read2_i    (read2i),
    .lu_stall_o (lu_stall)
  );

  // Bundle the decode outputs into one latch record.
  always_comb begin
    cap           = ID_EX_BUBBLE;
    cap.rdat1     = rdat1i;
    cap.rdat2     = rdat2i;
    cap.imm       = immi;
    cap.laddr     = laddri;
    cap.pc_addr   = pcAddrOuti;
    cap.read1     = read1i;
    cap.read2     = read2i;
    cap.wsel      = wseli;
    cap.op        = aluop_t'(opi);
    cap.opcode    = opcode_t'(decode_opcodei);
    cap.beq       = beqi;
    cap.bne       = bnei;
    cap.jsig      = jsigi;
    cap.jrsig     = jrsigi;
    cap.dren      = dRENi;
    cap.dwen      = dWENi;
    cap.reg_wr    = reg_wri;
    cap.write_sig = write_sigi;
    cap.imm_sig   = immSigi;
    cap.halt      = halti;
  end

  // Update priority: flush, then load-use bubble, then capture, else hold.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush) begin
      ex_d = ID_EX_BUBBLE;
    end else if (decode_en && lu_stall) begin
      ex_d = ID_EX_BUBBLE;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (decode_en) begin
      ex_d = cap;
    end
  end

  // Latch record and bubble counter, cleared immediately on reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_q  <= ID_EX_BUBBLE;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdat1o         = ex_q.rdat1;
  assign rdat2o         = ex_q.rdat2;
  assign immo           = ex_q.imm;
  assign laddro         = ex_q.laddr;
  assign pcAddrOuto     = ex_q.pc_addr;
  assign read1o         = ex_q.read1;
  assign read2o         = ex_q.read2;
  assign wselo          = ex_q.wsel;
  assign opo            = ex_q.op;
  assign decode_opcodeo = ex_q.opcode;
  assign beqo           = ex_q.beq;
  assign bneo           = ex_q.bne;
  assign jsigo          = ex_q.jsig;
  assign jrsigo         = ex_q.jrsig;
  assign dRENo          = ex_q.dren;
  assign dWENo          = ex_q.dwen;
  assign reg_wro        = ex_q.reg_wr;
  assign write_sigo     = ex_q.write_sig;
  assign immSigo        = ex_q.imm_sig;
  assign halto          = ex_q.halt;
  assign bubble_cnt     = cnt_q;

endmodule

// File: tb/tb_decode_execute_latch.sv
// Bench for decode_execute_latch: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_decode_execute_latch;

  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic        flush, decode_en;
  logic [31:0] rdat1i, rdat2i, immi, laddri, pcAddrOuti;
  logic [4:0]  read1i, read2i, wseli;
  logic [3:0]  opi;
  logic [5:0]  decode_opcodei;
  logic        beqi, bnei, jsigi, jrsigi, dRENi, dWENi, reg_wri, write_sigi, immSigi, halti;

  logic [31:0] rdat1o, rdat2o, immo, laddro, pcAddrOuto;
  logic [4:0]  read1o, read2o, wselo;
  logic [3:0]  opo;
  logic [5:0]  decode_opcodeo;
  logic        beqo, bneo, jsigo, jrsigo, dRENo, dWENo, reg_wro, write_sigo, immSigo, halto;
  logic        lu_stall;
  logic [CW-1:0] bubble_cnt;

  decode_execute_latch #(.DW(32), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush), .decode_en(decode_en),
    .rdat1i(rdat1i), .rdat2i(rdat2i), .immi(immi), .laddri(laddri), .pcAddrOuti(pcAddrOuti),
    .read1i(read1i), .read2i(read2i), .wseli(wseli), .opi(opi), .decode_opcodei(decode_opcodei),
    .beqi(beqi), .bnei(bnei), .jsigi(jsigi), .jrsigi(jrsigi), .dRENi(dRENi), .dWENi(dWENi),
    .reg_wri(reg_wri), .write_sigi(write_sigi), .immSigi(immSigi), .halti(halti),
    .rdat1o(rdat1o), .rdat2o(rdat2o), .immo(immo), .laddro(laddro), .pcAddrOuto(pcAddrOuto),
    .read1o(read1o), .read2o(read2o), .wselo(wselo), .opo(opo), .decode_opcodeo(decode_opcodeo),
    .beqo(beqo), .bneo(bneo), .jsigo(jsigo), .jrsigo(jrsigo), .dRENo(dRENo), .dWENo(dWENo),
    .reg_wro(reg_wro), .write_sigo(write_sigo), .immSigo(immSigo), .halto(halto),
    .lu_stall(lu_stall), .bubble_cnt(bubble_cnt)
  );

  typedef struct packed {
    logic [31:0] rdat1, rdat2, imm, laddr, pc;
    logic [4:0]  r1, r2, ws;
    logic [3:0]  op;
    logic [5:0]  opc;
    logic beq, bne, jsig, jrsig, dren, dwen, regwr, wsig, imms, halt;
  } ins_t;

  ins_t        m_q;
  int unsigned m_cnt;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic ins_t cur_in();
    ins_t t;
    t.rdat1 = rdat1i; t.rdat2 = rdat2i; t.imm = immi; t.laddr = laddri; t.pc = pcAddrOuti;
    t.r1 = read1i; t.r2 = read2i; t.ws = wseli; t.op = opi; t.opc = decode_opcodei;
    t.beq = beqi; t.bne = bnei; t.jsig = jsigi; t.jrsig = jrsigi; t.dren = dRENi;
    t.dwen = dWENi; t.regwr = reg_wri; t.wsig = write_sigi; t.imms = immSigi; t.halt = halti;
    return t;
  endfunction

  function automatic logic m_haz();
    return m_q.dren && m_q.regwr && (m_q.ws != 5'd0) &&
           ((m_q.ws == read1i) || (m_q.ws == read2i));
  endfunction

  function automatic logic [CW-1:0] m_cnt_exp();
    return (m_cnt > CMAX) ? CW'(CMAX) : CW'(m_cnt);
  endfunction

  // What the latch must hold after a rising edge, given the inputs seen at that edge.
  task automatic model_edge();
    if (flush) m_q = '0;
    else if (decode_en && m_haz()) begin
      m_q = '0;
      m_cnt++;
    end else if (decode_en) m_q = cur_in();
  endtask

  task automatic check_all();
    chk("rdat1o", 64'(rdat1o), 64'(m_q.rdat1));
    chk("rdat2o", 64'(rdat2o), 64'(m_q.rdat2));
    chk("immo", 64'(immo), 64'(m_q.imm));
    chk("laddro", 64'(laddro), 64'(m_q.laddr));
    chk("pcAddrOuto", 64'(pcAddrOuto), 64'(m_q.pc));
    chk("read1o", 64'(read1o), 64'(m_q.r1));
    chk("read2o", 64'(read2o), 64'(m_q.r2));
    chk("wselo", 64'(wselo), 64'(m_q.ws));
    chk("opo", 64'(opo), 64'(m_q.op));
    chk("opcodeo", 64'(decode_opcodeo), 64'(m_q.opc));
    chk("ctl", 64'({beqo, bneo, jsigo, jrsigo, dRENo, dWENo, reg_wro, write_sigo, immSigo, halto}),
        64'({m_q.beq, m_q.bne, m_q.jsig, m_q.jrsig, m_q.dren, m_q.dwen, m_q.regwr,
             m_q.wsig, m_q.imms, m_q.halt}));
    chk("lu_stall", 64'(lu_stall), 64'(m_haz()));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt_exp()));
  endtask

  // Called with inputs already set after a falling edge; returns at the next falling edge.
  task automatic step();
    #1 check_all();
    @(posedge CLK);
    if (nRST) model_edge();
    @(negedge CLK);
  endtask

  task automatic clear_in();
    flush = 0; decode_en = 0;
    rdat1i = 0; rdat2i = 0; immi = 0; laddri = 0; pcAddrOuti = 0;
    read1i = 0; read2i = 0; wseli = 0; opi = 0; decode_opcodei = 0;
    beqi = 0; bnei = 0; jsigi = 0; jrsigi = 0; dRENi = 0; dWENi = 0;
    reg_wri = 0; write_sigi = 0; immSigi = 0; halti = 0;
  endtask

  task automatic set_lw(input logic [4:0] ws);
    clear_in();
    decode_en = 1; dRENi = 1; reg_wri = 1; wseli = ws;
    decode_opcodei = 6'h23; opi = 4'd2; immi = 32'h10; rdat1i = 32'h1000;
  endtask

  task automatic set_dep(input logic [4:0] rs);
    clear_in();
    decode_en = 1; read2i = rs; read1i = 5'd3; wseli = 5'd9; reg_wri = 1;
    rdat2i = 32'h1234;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    #2 nRST = 0;
    #1;
    m_q = '0;
    m_cnt = 0;
    chk("rst_rdat1o", 64'(rdat1o), 64'h0);
    chk("rst_opcodeo", 64'(decode_opcodeo), 64'h0);
    chk("rst_dRENo", 64'(dRENo), 64'h0);
    chk("rst_cnt", 64'(bubble_cnt), 64'h0);
    check_all();
    @(negedge CLK);
    nRST = 1;
  endtask

  initial begin
    clear_in();
    m_q = '0;
    m_cnt = 0;
    repeat (2) @(negedge CLK);
    chk("init_lu_stall", 64'(lu_stall), 64'h0);
    chk("init_opcodeo", 64'(decode_opcodeo), 64'h0);
    nRST = 1;

    // Capture
    clear_in();
    decode_en = 1; rdat1i = 32'hDEADBEEF; wseli = 5'd5; reg_wri = 1;
    step();
    chk("cap_rdat1o", 64'(rdat1o), 64'hDEADBEEF);
    chk("cap_wselo", 64'(wselo), 64'd5);
    chk("cap_reg_wro", 64'(reg_wro), 64'd1);

    // Load-use bubble then the dependent instruction captures
    set_lw(5'd8);
    step();
    set_dep(5'd8);
    #1 chk("lu_assert", 64'(lu_stall), 64'd1);
    step();
    chk("lu_bubble_dren", 64'(dRENo), 64'd0);
    chk("lu_bubble_cnt", 64'(bubble_cnt), 64'd1);
    chk("lu_after_stall", 64'(lu_stall), 64'd0);
    step();
    chk("lu_dep_read2o", 64'(read2o), 64'd8);
    chk("lu_dep_wselo", 64'(wselo), 64'd9);

    // Flush overrides the load-use bubble and is not counted
    set_lw(5'd8);
    step();
    set_dep(5'd8);
    flush = 1;
    step();
    flush = 0;
    chk("flush_cnt", 64'(bubble_cnt), 64'd1);
    chk("flush_wselo", 64'(wselo), 64'd0);
    chk("flush_dren", 64'(dRENo), 64'd0);

    // Hold with hazard present: frozen, stall still visible, no count
    set_lw(5'd8);
    step();
    for (int k = 0; k < 3; k++) begin
      set_dep(5'd8);
      decode_en = 0;
      rdat1i = $urandom;
      rdat2i = $urandom;
      #1 chk("hold_lu", 64'(lu_stall), 64'd1);
      step();
      chk("hold_wselo", 64'(wselo), 64'd8);
      chk("hold_dren", 64'(dRENo), 64'd1);
      chk("hold_cnt", 64'(bubble_cnt), 64'd1);
    end

    // $zero destination never stalls
    set_lw(5'd0);
    step();
    clear_in();
    decode_en = 1;
    #1 chk("zero_lu", 64'(lu_stall), 64'd0);
    step();

    // Saturation at 2'b11
    for (int k = 0; k < 5; k++) begin
      set_lw(5'd8);
      step();
      set_dep(5'd8);
      step();
    end
    chk("sat_cnt", 64'(bubble_cnt), 64'd3);

    // Mid-operation reset with fields and counter loaded
    set_lw(5'd7);
    halti = 1;
    step();
    do_reset();

    // Randomized traffic with a narrow register range to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) do_reset();
      flush = ($urandom_range(0, 15) == 0);
      decode_en = ($urandom_range(0, 3) != 0);
      rdat1i = $urandom; rdat2i = $urandom; immi = $urandom;
      laddri = $urandom; pcAddrOuti = $urandom;
      read1i = 5'($urandom_range(0, 3));
      read2i = 5'($urandom_range(0, 3));
      wseli  = 5'($urandom_range(0, 3));
      opi = 4'($urandom_range(0, 9));
      decode_opcodei = 6'($urandom);
      {beqi, bnei, jsigi, jrsigi, dWENi, write_sigi, immSigi, halti} = 8'($urandom);
      dRENi = $urandom_range(0, 1) == 1;
      reg_wri = $urandom_range(0, 9) < 7;
      step();
    end
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
